// File: rtl/mem_req_queue.sv
// mem_req_queue
// -------------
// In-order request queue sitting in front of main_memory. Accepts single-word
// read/write requests from the core side, buffers them in a FIFO, issues them
// one at a time on the memory bus as R_REQ / WB_REQ, waits for MEM_RESP and
// returns a one-cycle response pulse.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is simply !full. The response side has no backpressure; resp_valid
// is a single-cycle pulse and all resp_* fields are 0 while it is low.
//
// Ports:
//   clock, reset                 single clock, synchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_write/address/data       request payload (data ignored for reads)
//   resp_valid/write/error       completion pulse and its attributes
//   resp_address/resp_data       completed address, read data (0 for writes)
//   msg_out/address_out/data_out bus request to memory (registered)
//   msg_in/address_in/data_in    bus response from memory
//   fsm_state                    debug view of the FSM (0 = IDLE, 1 = WAIT)
//
// Optional feature macro: MEM_REQ_TIMEOUT_EN
//   When defined, a request that sees no MEM_RESP within TIMEOUT_CYCLES WAIT
//   cycles is completed with resp_error = 1. When undefined, WAIT has no limit
//   and resp_error is constant 0.

module mem_req_queue #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int MSG_BITS       = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]    req_data,
    output logic                     resp_valid,
    output logic                     resp_write,
    output logic                     resp_error,
    output logic [ADDRESS_WIDTH-1:0] resp_address,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic [MSG_BITS-1:0]      msg_out,
    output logic [ADDRESS_WIDTH-1:0] address_out,
    output logic [DATA_WIDTH-1:0]    data_out,
    input  logic [MSG_BITS-1:0]      msg_in,
    input  logic [ADDRESS_WIDTH-1:0] address_in,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic                     fsm_state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [MSG_BITS-1:0] NO_REQ   = MSG_BITS'(0);
    localparam logic [MSG_BITS-1:0] R_REQ    = MSG_BITS'(1);
    localparam logic [MSG_BITS-1:0] WB_REQ   = MSG_BITS'(2);
    localparam logic [MSG_BITS-1:0] MEM_RESP = MSG_BITS'(10);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    // ---------------- FIFO ----------------
    logic                     fifo_write [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_data  [FIFO_DEPTH];
    logic [PW-1:0]            wptr, rptr;
    logic [PW:0]              count;     // extra bit separates full from empty
    logic                     full, empty, push, pop;

    state_t state_q, state_d;

    assign full      = (count == (PW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    // Pop only from IDLE, so IDLE always lasts at least one cycle between requests.
    assign pop       = (state_q == S_IDLE) && !empty;

    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_write[wptr] <= req_write;
            fifo_addr[wptr]  <= req_address;
            fifo_data[wptr]  <= req_data;
        end
    end

    // ---------------- response detection / timeout ----------------
    logic resp_hit, timeout;
    assign resp_hit = (state_q == S_WAIT) && (msg_in == MEM_RESP);

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;

    // Expiry fires on the edge closing the TIMEOUT_CYCLES-th WAIT cycle;
    // a coincident MEM_RESP wins.
    assign timeout = (state_q == S_WAIT) && !resp_hit &&
                     (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (!reset || state_q != S_WAIT) wait_cnt <= '0;
        else                             wait_cnt <= wait_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!empty)             state_d = S_WAIT;
            S_WAIT:  if (resp_hit || timeout) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (next values, registered below) ----------------
    logic [MSG_BITS-1:0]      msg_d;
    logic [ADDRESS_WIDTH-1:0] address_d;
    logic [DATA_WIDTH-1:0]    data_d;
    logic                     resp_valid_d, resp_write_d, resp_error_d;
    logic [ADDRESS_WIDTH-1:0] resp_address_d;
    logic [DATA_WIDTH-1:0]    resp_data_d;
    logic                     head_write;

    assign head_write = fifo_write[rptr];

    always_comb begin
        msg_d          = msg_out;
        address_d      = address_out;
        data_d         = data_out;
        resp_valid_d   = 1'b0;
        resp_write_d   = 1'b0;
        resp_error_d   = 1'b0;
        resp_address_d = '0;
        resp_data_d    = '0;
        case (state_q)
            S_IDLE: begin
                msg_d     = NO_REQ;
                address_d = '0;
                data_d    = '0;
                if (!empty) begin
                    msg_d     = head_write ? WB_REQ : R_REQ;
                    address_d = fifo_addr[rptr];
                    data_d    = head_write ? fifo_data[rptr] : '0;
                end
            end
            S_WAIT: begin
                if (resp_hit || timeout) begin
                    msg_d          = NO_REQ;
                    address_d      = '0;
                    data_d         = '0;
                    resp_valid_d   = 1'b1;
                    resp_write_d   = (msg_out == WB_REQ);
                    resp_error_d   = timeout;
                    resp_address_d = address_out;
                    resp_data_d    = (resp_hit && msg_out != WB_REQ) ? data_in : '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            msg_out      <= NO_REQ;
            address_out  <= '0;
            data_out     <= '0;
            resp_valid   <= 1'b0;
            resp_write   <= 1'b0;
            resp_error   <= 1'b0;
            resp_address <= '0;
            resp_data    <= '0;
        end else begin
            msg_out      <= msg_d;
            address_out  <= address_d;
            data_out     <= data_d;
            resp_valid   <= resp_valid_d;
            resp_write   <= resp_write_d;
            resp_error   <= resp_error_d;
            resp_address <= resp_address_d;
            resp_data    <= resp_data_d;
        end
    end

    assign fsm_state = state_q;

    // The response address is not used for matching: only one request is in flight.
    logic unused_inputs;
    assign unused_inputs = ^address_in ^ (TIMEOUT_CYCLES != 0);

endmodule

// File: tb/tb_mem_req_queue.sv
module tb_mem_req_queue;

    localparam logic [3:0] NO_REQ = 4'd0, R_REQ = 4'd1, WB_REQ = 4'd2, MEM_RESP = 4'd10;
`ifdef MEM_REQ_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_address = '0;
    logic [31:0] req_data = '0;
    logic        resp_valid, resp_write, resp_error;
    logic [31:0] resp_address, resp_data;
    logic [3:0]  msg_out;
    logic [31:0] address_out, data_out;
    logic [3:0]  msg_in;
    logic [31:0] data_in;
    logic        fsm_state;

    // memory model / injection
    logic        mem_en  = 1'b1;
    logic [3:0]  inj_msg = NO_REQ;
    logic [3:0]  mem_msg = NO_REQ;
    logic [31:0] mem_rdata = '0;
    int          mem_cnt = 0;
    logic [31:0] mem [logic [7:0]];

    assign msg_in  = mem_en ? mem_msg : inj_msg;
    assign data_in = mem_rdata;

    mem_req_queue #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_data(req_data),
        .resp_valid(resp_valid), .resp_write(resp_write), .resp_error(resp_error),
        .resp_address(resp_address), .resp_data(resp_data),
        .msg_out(msg_out), .address_out(address_out), .data_out(data_out),
        .msg_in(msg_in), .address_in(32'h0), .data_in(data_in),
        .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // Memory model with main_memory timing: a write answers on the second cycle
    // the request is visible, a read on the third. Driven on falling edges.
    always @(negedge clock) begin
        if (!mem_en || mem_msg == MEM_RESP) begin
            mem_msg = NO_REQ; mem_rdata = '0; mem_cnt = 0;
        end else if (msg_out == WB_REQ) begin
            mem_cnt++;
            if (mem_cnt == 2) begin
                mem[address_out[7:0]] = data_out;
                mem_msg = MEM_RESP;
            end
        end else if (msg_out == R_REQ) begin
            mem_cnt++;
            if (mem_cnt == 3) begin
                if (mem.exists(address_out[7:0])) mem_rdata = mem[address_out[7:0]];
                else if (address_out[7:0] == 8'h10) mem_rdata = 32'hCAFEF00D;
                else mem_rdata = 32'h0;
                mem_msg = MEM_RESP;
            end
        end
    end

    // ---------------- checking ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [64:0] exp_q[$];

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one request at a falling edge; returns whether it was accepted.
    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d, output logic acc);
        acc = req_ready;
        req_valid = 1'b1; req_write = w; req_address = a; req_data = d;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_data = '0;
    endtask

    logic acc;
    int   cyc, n_resp, gap, wr_cyc, rd_cyc;
    logic saw_wb, saw_rd;
    logic [31:0] wr_data, wr_addr, rd_data;
    logic [64:0] exp_e;

    initial begin
        // ---- reset ----
        repeat (3) @(negedge clock);
        check("reset_ready", req_ready, 1);
        check("reset_msg", msg_out, NO_REQ);
        check("reset_addr", address_out, 0);
        check("reset_resp_valid", resp_valid, 0);
        reset = 1'b1;
        @(negedge clock);

        // ---- single read ----
        push(1'b0, 32'h10, 32'h0, acc);
        @(negedge clock);
        check("rd_bus_msg", msg_out, R_REQ);
        check("rd_bus_addr", address_out, 32'h10);
        cyc = 1;
        while (!resp_valid && cyc < 20) begin @(negedge clock); cyc++; end
        check("rd_latency", cyc, 4);
        check("rd_data", resp_data, 32'hCAFEF00D);
        check("rd_write_flag", resp_write, 0);
        @(negedge clock);
        check("rd_pulse_width", resp_valid, 0);
        check("rd_idle_fields", {resp_write, resp_address, resp_data}, 0);

        // ---- write then read same address ----
        push(1'b1, 32'h20, 32'hDEADBEEF, acc);
        push(1'b0, 32'h20, 32'h0, acc);
        // time origin: edge of the write acceptance, which is one edge back
        cyc = 1; gap = 0; saw_wb = 0; saw_rd = 0; wr_cyc = 0; rd_cyc = 0;
        wr_data = 32'hFFFFFFFF; wr_addr = '0; rd_data = '0;
        while (cyc < 15) begin
            if (msg_out == WB_REQ) saw_wb = 1;
            if (msg_out == R_REQ) saw_rd = 1;
            if (saw_wb && !saw_rd && msg_out == NO_REQ) gap++;
            if (resp_valid && resp_write) begin wr_cyc = cyc; wr_data = resp_data; wr_addr = resp_address; end
            if (resp_valid && !resp_write) begin rd_cyc = cyc; rd_data = resp_data; end
            @(negedge clock); cyc++;
        end
        check("wr_latency", wr_cyc, 3);
        check("wr_resp_data", wr_data, 0);
        check("wr_resp_addr", wr_addr, 32'h20);
        check("wr_rd_gap", gap, 1);
        check("rd_after_wr_data", rd_data, 32'hDEADBEEF);
        check("rd_after_wr_latency", rd_cyc, 7);

        // ---- fill the queue with memory silent ----
        mem_en = 1'b0;
        push(1'b1, 32'h40, 32'h11111111, acc); check("fill_acc0", acc, 1);
        exp_q.push_back({1'b1, 32'h40, 32'h0});
        push(1'b0, 32'h40, 32'h0, acc);        check("fill_acc1", acc, 1);
        exp_q.push_back({1'b0, 32'h40, 32'h11111111});
        push(1'b1, 32'h44, 32'h22222222, acc); check("fill_acc2", acc, 1);
        exp_q.push_back({1'b1, 32'h44, 32'h0});
        push(1'b0, 32'h44, 32'h0, acc);        check("fill_acc3", acc, 1);
        exp_q.push_back({1'b0, 32'h44, 32'h22222222});
        push(1'b0, 32'h10, 32'h0, acc);        check("fill_acc4", acc, 1);
        exp_q.push_back({1'b0, 32'h10, 32'hCAFEF00D});
        check("full_ready_low", req_ready, 0);
        check("full_in_wait", fsm_state, 1);
        mem_en = 1'b1;
        n_resp = 0; cyc = 0;
        while (n_resp < 5 && cyc < 100) begin
            @(negedge clock); cyc++;
            if (resp_valid) begin
                n_resp++;
                if (exp_q.size() == 0) check("unexpected_resp", 1, 0);
                else begin
                    exp_e = exp_q.pop_front();
                    check("order_resp", {resp_write, resp_address, resp_data}, exp_e);
                end
            end
        end
        check("order_count", n_resp, 5);
        @(negedge clock);
        check("order_ready_back", req_ready, 1);

        // ---- reset during WAIT of a read ----
        mem_en = 1'b0;
        push(1'b0, 32'h10, 32'h0, acc);
        repeat (2) @(negedge clock);
        check("rst_pre_wait", fsm_state, 1);
        reset = 1'b0;
        @(negedge clock);
        check("rst_msg", msg_out, NO_REQ);
        check("rst_ready", req_ready, 1);
        check("rst_state", fsm_state, 0);
        reset = 1'b1;
        mem_en = 1'b1;
        n_resp = 0;
        repeat (20) begin @(negedge clock); if (resp_valid) n_resp++; end
        check("rst_no_resp", n_resp, 0);

        // ---- no MEM_RESP ever ----
        mem_en = 1'b0;
        push(1'b0, 32'h30, 32'h0, acc);
        cyc = 0;
        while (!resp_valid && cyc < 1000) begin @(negedge clock); cyc++; end
`ifdef MEM_REQ_TIMEOUT_EN
        check("to_cycle", cyc, 9);
        check("to_flags", {resp_valid, resp_error, resp_write}, 3'b110);
        check("to_addr", resp_address, 32'h30);
        check("to_data", resp_data, 0);
        check("to_msg", msg_out, NO_REQ);
        @(negedge clock);
        check("to_pulse_width", resp_valid, 0);
`else
        check("no_to_resp", resp_valid, 0);
        check("no_to_msg", msg_out, R_REQ);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
`endif
        @(negedge clock);

        // ---- MEM_RESP while idle and empty ----
        inj_msg = MEM_RESP;
        n_resp = 0;
        repeat (3) begin @(negedge clock); if (resp_valid) n_resp++; end
        inj_msg = NO_REQ;
        check("idle_resp_none", n_resp, 0);
        check("idle_resp_state", fsm_state, 0);
        check("idle_resp_msg", msg_out, NO_REQ);
        mem_en = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop so the bench always ends even if a loop above misbehaves.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
